bvmul_inv_search_ctrl: RTL



---
 rtl/bvmul_inv_search_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bvmul_inv_search_ctrl.sv
// bvmul_inv_search_ctrl
//   Sequential solver for a*x == b (mod 2^W). A request (a, b) is accepted in
//   IDLE. Pairs that provably have no solution are rejected in one cycle.
//   Otherwise a candidate counter is stepped through one shared W-bit
//   multiplier, and the smallest satisfying x is returned.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake; ready only in IDLE
//   req_a, req_b            multiplicand a, target b
//   abort                   synchronous cancel in SEARCH or RESP
//   rsp_valid/rsp_ready     response handshake
//   rsp_x, rsp_found        smallest solution, and whether one exists
//   rsp_cycles              SEARCH cycles spent (0 when rejected up front)
//   busy                    state != IDLE
//   solved_cnt              saturating count of delivered found responses
//   unsolved_cnt            saturating count of delivered not-found responses
module bvmul_inv_search_ctrl #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_x,
  output logic             rsp_found,
  output logic [W:0]       rsp_cycles,
  output logic             busy,
  output logic [CNT_W-1:0] solved_cnt,
  output logic [CNT_W-1:0] unsolved_cnt
);

  typedef enum logic [1:0] {StIdle, StSearch, StResp} state_e;

  state_e           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     cand_q;
  logic [W:0]       cycles_q;
  logic [W-1:0]     x_q;
  logic             found_q;
  logic [CNT_W-1:0] solved_q;
  logic [CNT_W-1:0] unsolved_q;

  // Trailing-zero count. Returns W for a zero operand; callers screen out zero.
  function automatic int unsigned ctz(input logic [W-1:0] v);
    int unsigned n;
    n = W;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (v[i]) n = unsigned'(i);
    end
    return n;
  endfunction

  // a*x can only reach b when a has no more trailing zeros than b
  // (the odd part of a is invertible mod 2^W).
  logic unsolvable;
  assign unsolvable = (req_b != '0) && ((req_a == '0) || (ctz(req_a) > ctz(req_b)));

  // The single shared multiplier, truncated to W bits.
  logic [W-1:0] prod;
  assign prod = a_q * cand_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      cand_q     <= '0;
      cycles_q   <= '0;
      x_q        <= '0;
      found_q    <= 1'b0;
      solved_q   <= '0;
      unsolved_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            a_q      <= req_a;
            b_q      <= req_b;
            cand_q   <= '0;
            cycles_q <= '0;
            if (unsolvable) begin
              x_q     <= '0;
              found_q <= 1'b0;
              state_q <= StResp;
            end else begin
              state_q <= StSearch;
            end
          end
        end
        StSearch: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            cycles_q <= cycles_q + 1'b1;
            if (prod == b_q) begin
              x_q     <= cand_q;
              found_q <= 1'b1;
              state_q <= StResp;
            end else if (cand_q == '1) begin
              // Exhausted; only reachable if the precheck were bypassed.
              x_q     <= '0;
              found_q <= 1'b0;
              state_q <= StResp;
            end else begin
              cand_q <= cand_q + 1'b1;
            end
          end
        end
        StResp: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (rsp_ready) begin
            if (found_q) begin
              if (solved_q != '1) solved_q <= solved_q + 1'b1;
            end else begin
              if (unsolved_q != '1) unsolved_q <= unsolved_q + 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_x        = x_q;
  assign rsp_found    = found_q;
  assign rsp_cycles   = cycles_q;
  assign solved_cnt   = solved_q;
  assign unsolved_cnt = unsolved_q;

endmodule
